// File: rtl/riscv_fwd_pkg.sv
// Shared types and constants for the dual-issue forwarding/hazard controller.
// Forwarding select codes, in-flight tag entries and the stage/pipe to code mapping.
package riscv_fwd_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned SEL_W      = 3;
    localparam int unsigned NUM_STAGES = 3;  // EX, MEM, WB
    localparam int unsigned NUM_SRCS   = 4;  // b_rs1, b_rs2, m_rs1, m_rs2

    // The code names where the producer sat while the consumer was in ID.
    typedef enum logic [SEL_W-1:0] {
        FwdNormal    = 3'b000,
        FwdBranchEx  = 3'b001,
        FwdMemEx     = 3'b010,
        FwdBranchMem = 3'b011,
        FwdMemMem    = 3'b100,
        FwdBranchWb  = 3'b101,
        FwdMemWb     = 3'b110
    } fwd_sel_t;

    typedef enum logic [1:0] {
        StageEx  = 2'd0,
        StageMem = 2'd1,
        StageWb  = 2'd2
    } fwd_stage_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic                  is_load;
    } tag_entry_t;

    function automatic logic tag_hit(input tag_entry_t t, input logic [REG_ADDR_W-1:0] rs);
        return t.valid && t.we && (t.rd == rs);
    endfunction

    function automatic fwd_sel_t fwd_code(input fwd_stage_t stage, input logic from_m);
        fwd_sel_t code;
        case (stage)
            StageEx:  code = from_m ? FwdMemEx  : FwdBranchEx;
            StageMem: code = from_m ? FwdMemMem : FwdBranchMem;
            StageWb:  code = from_m ? FwdMemWb  : FwdBranchWb;
            default:  code = FwdNormal;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/forwarding_control_unit_if.sv
// Decode-side bundle between the core and the forwarding controller.
// master = core (drives the ID pair and pipeline control), slave = forwarding_control_unit.
interface forwarding_control_unit_if;
    import riscv_fwd_pkg::*;

    logic                  id_b_valid;
    logic [REG_ADDR_W-1:0] id_b_rs1;
    logic [REG_ADDR_W-1:0] id_b_rs2;
    logic [REG_ADDR_W-1:0] id_b_rd;
    logic                  id_b_we;

    logic                  id_m_valid;
    logic [REG_ADDR_W-1:0] id_m_rs1;
    logic [REG_ADDR_W-1:0] id_m_rs2;
    logic [REG_ADDR_W-1:0] id_m_rd;
    logic                  id_m_we;
    logic                  id_m_is_load;
    logic                  id_m_older;

    logic                  pipe_hold;
    logic                  flush_ex;

    logic [SEL_W-1:0]      b_rs1_sel;
    logic [SEL_W-1:0]      b_rs2_sel;
    logic [SEL_W-1:0]      m_rs1_sel;
    logic [SEL_W-1:0]      m_rs2_sel;
    logic                  load_use_stall;

    modport master (
        output id_b_valid, id_b_rs1, id_b_rs2, id_b_rd, id_b_we,
        output id_m_valid, id_m_rs1, id_m_rs2, id_m_rd, id_m_we, id_m_is_load, id_m_older,
        output pipe_hold, flush_ex,
        input  b_rs1_sel, b_rs2_sel, m_rs1_sel, m_rs2_sel, load_use_stall
    );

    modport slave (
        input  id_b_valid, id_b_rs1, id_b_rs2, id_b_rd, id_b_we,
        input  id_m_valid, id_m_rs1, id_m_rs2, id_m_rd, id_m_we, id_m_is_load, id_m_older,
        input  pipe_hold, flush_ex,
        output b_rs1_sel, b_rs2_sel, m_rs1_sel, m_rs2_sel, load_use_stall
    );

endinterface

// File: rtl/fwd_src_resolve.sv
// Priority comparator for one source operand against the B and M tag pipes.
// Nearest stage wins; within a stage the younger instruction of the pair wins.
module fwd_src_resolve
    import riscv_fwd_pkg::*;
(
    input  logic                              src_valid,
    input  logic [REG_ADDR_W-1:0]             rs,
    input  tag_entry_t [NUM_STAGES-1:0]       b_tag,
    input  tag_entry_t [NUM_STAGES-1:0]       m_tag,
    input  logic [NUM_STAGES-1:0]             m_younger,
    output fwd_sel_t                          sel,
    output logic                              load_hit
);

    logic [NUM_STAGES-1:0] b_hit;
    logic [NUM_STAGES-1:0] m_hit;
    logic                  use_m;

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_hit
        assign b_hit[s] = tag_hit(b_tag[s], rs);
        assign m_hit[s] = tag_hit(m_tag[s], rs);
    end

    // Scan oldest to youngest so the last hit written (EX side) has priority.
    always_comb begin
        sel      = FwdNormal;
        load_hit = 1'b0;
        use_m    = 1'b0;
        if (src_valid && (rs != '0)) begin
            for (int s = NUM_STAGES - 1; s >= 0; s--) begin
                if (b_hit[s] || m_hit[s]) begin
                    use_m    = m_hit[s] && (!b_hit[s] || m_younger[s]);
                    sel      = fwd_code(fwd_stage_t'(s), use_m);
                    load_hit = (s == 0) && use_m && m_tag[s].is_load;
                end
            end
        end
    end

    // Only the M pipe carries loads; the B-side flag never matters.
    logic unused_b_load;
    assign unused_b_load = ^{b_tag[0].is_load, b_tag[1].is_load, b_tag[2].is_load};

endmodule

// File: rtl/forwarding_control_unit.sv
// Decode-stage hazard and forwarding controller for the B/M dual-issue pipe.
// Optional FWD_STATS_EN adds stall-cycle and forward-event counters (stat_stalls, stat_fwds).
module forwarding_control_unit
    import riscv_fwd_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    forwarding_control_unit_if.slave    fcu
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]                 stat_stalls,
    output logic [31:0]                 stat_fwds
`endif
);

    tag_entry_t [NUM_STAGES-1:0] b_tag_q;
    tag_entry_t [NUM_STAGES-1:0] m_tag_q;
    logic [NUM_STAGES-1:0]       m_younger_q;
    tag_entry_t                  b_ex_d;
    tag_entry_t                  m_ex_d;
    logic                        m_younger_d;

    logic [REG_ADDR_W-1:0]       src_rs [NUM_SRCS];
    logic                        src_valid [NUM_SRCS];
    fwd_sel_t                    res_sel [NUM_SRCS];
    logic [NUM_SRCS-1:0]         res_load;
    fwd_sel_t                    sel_d [NUM_SRCS];
    fwd_sel_t                    sel_q [NUM_SRCS];

    logic                        stall;
    logic                        bubble_ex;

    assign src_rs[0]    = fcu.id_b_rs1;
    assign src_rs[1]    = fcu.id_b_rs2;
    assign src_rs[2]    = fcu.id_m_rs1;
    assign src_rs[3]    = fcu.id_m_rs2;
    assign src_valid[0] = fcu.id_b_valid;
    assign src_valid[1] = fcu.id_b_valid;
    assign src_valid[2] = fcu.id_m_valid;
    assign src_valid[3] = fcu.id_m_valid;

    for (genvar i = 0; i < NUM_SRCS; i++) begin : g_res
        fwd_src_resolve u_resolve (
            .src_valid (src_valid[i]),
            .rs        (src_rs[i]),
            .b_tag     (b_tag_q),
            .m_tag     (m_tag_q),
            .m_younger (m_younger_q),
            .sel       (res_sel[i]),
            .load_hit  (res_load[i])
        );
    end

    // A frozen pipe cannot stall, and a flush already squashes the consumer.
    assign stall     = (|res_load) && !fcu.pipe_hold && !fcu.flush_ex && !rst;
    assign bubble_ex = fcu.flush_ex || stall;

    always_comb begin
        b_ex_d      = '0;
        m_ex_d      = '0;
        m_younger_d = 1'b0;
        if (!bubble_ex) begin
            if (fcu.id_b_valid) begin
                b_ex_d.valid = 1'b1;
                b_ex_d.rd    = fcu.id_b_rd;
                b_ex_d.we    = fcu.id_b_we;
            end
            if (fcu.id_m_valid) begin
                m_ex_d.valid   = 1'b1;
                m_ex_d.rd      = fcu.id_m_rd;
                m_ex_d.we      = fcu.id_m_we;
                m_ex_d.is_load = fcu.id_m_is_load;
            end
            m_younger_d = !fcu.id_m_older;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SRCS; i++) begin
            sel_d[i] = bubble_ex ? FwdNormal : res_sel[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_tag_q     <= '0;
            m_tag_q     <= '0;
            m_younger_q <= '0;
            for (int i = 0; i < NUM_SRCS; i++) begin
                sel_q[i] <= FwdNormal;
            end
        end else if (!fcu.pipe_hold) begin
            b_tag_q     <= {b_tag_q[1:0], b_ex_d};
            m_tag_q     <= {m_tag_q[1:0], m_ex_d};
            m_younger_q <= {m_younger_q[1:0], m_younger_d};
            for (int i = 0; i < NUM_SRCS; i++) begin
                sel_q[i] <= sel_d[i];
            end
        end
    end

    assign fcu.b_rs1_sel      = sel_q[0];
    assign fcu.b_rs2_sel      = sel_q[1];
    assign fcu.m_rs1_sel      = sel_q[2];
    assign fcu.m_rs2_sel      = sel_q[3];
    assign fcu.load_use_stall = stall;

`ifdef FWD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] fwd_cnt_q;
    logic [2:0]  fwd_inc;

    always_comb begin
        fwd_inc = '0;
        for (int i = 0; i < NUM_SRCS; i++) begin
            if (sel_d[i] != FwdNormal) begin
                fwd_inc = fwd_inc + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else if (!fcu.pipe_hold) begin
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            fwd_cnt_q <= fwd_cnt_q + 32'(fwd_inc);
        end
    end

    assign stat_stalls = stall_cnt_q;
    assign stat_fwds   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_forwarding_control_unit.sv
// Bench for forwarding_control_unit: directed cycle table, then random traffic
// checked against an in-flight instruction model.
module tb_forwarding_control_unit;
    import riscv_fwd_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    forwarding_control_unit_if fcu_if ();

`ifdef FWD_STATS_EN
    logic [31:0] stat_stalls;
    logic [31:0] stat_fwds;
`endif

    forwarding_control_unit dut (
        .clk (clk),
        .rst (rst),
        .fcu (fcu_if)
`ifdef FWD_STATS_EN
        ,
        .stat_stalls (stat_stalls),
        .stat_fwds   (stat_fwds)
`endif
    );

    typedef struct {
        bit rst, hold, flush;
        bit bv; logic [4:0] brs1, brs2, brd; bit bwe;
        bit mv; logic [4:0] mrs1, mrs2, mrd; bit mwe, mload, mold;
        bit stall; logic [11:0] sels;  // octal digits: b_rs1 b_rs2 m_rs1 m_rs2
    } vec_t;

    // One issued pair as it travels EX -> MEM -> WB; age 0 is EX.
    typedef struct packed {
        logic bv; logic [4:0] brd; logic bwe;
        logic mv; logic [4:0] mrd; logic mwe; logic mload; logic myoung;
    } mpair_t;

    mpair_t      inflight [3];
    logic [11:0] model_sels;
    int          passed = 0;
    int          total  = 0;
    vec_t        vecs [30];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %o, expected %o", name, act, exp);
    endtask

    // Youngest producer in the nearest in-flight pair wins; code = 2*age + (1 for B, 2 for M).
    function automatic void model_resolve(input logic [4:0] rs, input logic slot_v,
                                          output int code, output bit load_ex);
        bit found = 0;
        bit is_m;
        bit hit;
        code    = 0;
        load_ex = 0;
        if (slot_v && rs != 0) begin
            for (int age = 0; age < 3; age++) begin
                for (int k = 0; k < 2; k++) begin
                    is_m = inflight[age].myoung ? (k == 0) : (k == 1);
                    hit  = is_m ? (inflight[age].mv && inflight[age].mwe && inflight[age].mrd == rs)
                                : (inflight[age].bv && inflight[age].bwe && inflight[age].brd == rs);
                    if (!found && hit) begin
                        found   = 1;
                        code    = 2 * age + (is_m ? 2 : 1);
                        load_ex = (age == 0) && is_m && inflight[age].mload;
                    end
                end
            end
        end
    endfunction

    task automatic drive(input vec_t v);
        rst                 = v.rst;
        fcu_if.pipe_hold    = v.hold;
        fcu_if.flush_ex     = v.flush;
        fcu_if.id_b_valid   = v.bv;
        fcu_if.id_b_rs1     = v.brs1;
        fcu_if.id_b_rs2     = v.brs2;
        fcu_if.id_b_rd      = v.brd;
        fcu_if.id_b_we      = v.bwe;
        fcu_if.id_m_valid   = v.mv;
        fcu_if.id_m_rs1     = v.mrs1;
        fcu_if.id_m_rs2     = v.mrs2;
        fcu_if.id_m_rd      = v.mrd;
        fcu_if.id_m_we      = v.mwe;
        fcu_if.id_m_is_load = v.mload;
        fcu_if.id_m_older   = v.mold;
    endtask

    // One clock: check stall mid-cycle, advance the model, check sels just after the edge.
    task automatic step(input string tag, input bit use_model, input bit exp_stall,
                        input logic [11:0] exp_sels);
        int     c [4];
        bit     le [4];
        bit     mstall;
        mpair_t np;
        #1;
        model_resolve(fcu_if.id_b_rs1, fcu_if.id_b_valid, c[0], le[0]);
        model_resolve(fcu_if.id_b_rs2, fcu_if.id_b_valid, c[1], le[1]);
        model_resolve(fcu_if.id_m_rs1, fcu_if.id_m_valid, c[2], le[2]);
        model_resolve(fcu_if.id_m_rs2, fcu_if.id_m_valid, c[3], le[3]);
        mstall = (le[0] || le[1] || le[2] || le[3]) && !fcu_if.pipe_hold && !fcu_if.flush_ex
                 && !rst;
        check({tag, " stall"}, {11'd0, fcu_if.load_use_stall},
              {11'd0, use_model ? mstall : exp_stall});
        if (rst) begin
            for (int a = 0; a < 3; a++) inflight[a] = '0;
            model_sels = '0;
        end else if (!fcu_if.pipe_hold) begin
            np = '0;
            if (!fcu_if.flush_ex && !mstall) begin
                np.bv     = fcu_if.id_b_valid;
                np.brd    = fcu_if.id_b_rd;
                np.bwe    = fcu_if.id_b_we;
                np.mv     = fcu_if.id_m_valid;
                np.mrd    = fcu_if.id_m_rd;
                np.mwe    = fcu_if.id_m_we;
                np.mload  = fcu_if.id_m_is_load;
                np.myoung = !fcu_if.id_m_older;
                model_sels = {c[0][2:0], c[1][2:0], c[2][2:0], c[3][2:0]};
            end else begin
                model_sels = '0;
            end
            inflight[2] = inflight[1];
            inflight[1] = inflight[0];
            inflight[0] = np;
        end
        @(posedge clk);
        #1;
        check({tag, " sels"},
              {fcu_if.b_rs1_sel, fcu_if.b_rs2_sel, fcu_if.m_rs1_sel, fcu_if.m_rs2_sel},
              use_model ? model_sels : exp_sels);
    endtask

    initial begin
        vec_t rv;
        for (int a = 0; a < 3; a++) inflight[a] = '0;
        model_sels = '0;

        //          rst hld fl  bv rs1 rs2 rd we  mv rs1 rs2 rd we ld old stl sels
        vecs[0]  = '{1, 0, 0,  0,  0,  0,  0, 0,  0,  0,  0,  0, 0, 0, 0,  0, 12'o0000};
        vecs[1]  = '{1, 0, 0,  0,  0,  0,  0, 0,  0,  0,  0,  0, 0, 0, 0,  0, 12'o0000};
        vecs[2]  = '{0, 0, 0,  1,  1,  2,  5, 1,  0,  0,  0,  0, 0, 0, 0,  0, 12'o0000};
        vecs[3]  = '{0, 0, 0,  0,  0,  0,  0, 0,  1,  5,  0,  6, 1, 0, 0,  0, 12'o0010};
        vecs[4]  = '{0, 0, 0,  1,  0,  0,  8, 1,  0,  0,  0,  0, 0, 0, 0,  0, 12'o0000};
        vecs[5]  = '{0, 0, 0,  0,  0,  0,  0, 0,  0,  0,  0,  0, 0, 0, 0,  0, 12'o0000};
        vecs[6]  = '{0, 0, 0,  0,  0,  0,  0, 0,  1,  8,  6,  0, 0, 0, 0,  0, 12'o0036};
        vecs[7]  = '{0, 0, 0,  0,  0,  0,  0, 0,  1,  1,  0,  7, 1, 1, 0,  0, 12'o0000};
        vecs[8]  = '{0, 0, 0,  1,  7,  0,  9, 1,  0,  0,  0,  0, 0, 0, 0,  1, 12'o0000};
        vecs[9]  = '{0, 0, 0,  1,  7,  0,  9, 1,  0,  0,  0,  0, 0, 0, 0,  0, 12'o4000};
        vecs[10] = '{0, 0, 0,  1,  0,  0,  3, 1,  1,  0,  0,  3, 1, 0, 0,  0, 12'o0000};
        vecs[11] = '{0, 0, 0,  1,  3,  0,  0, 0,  0,  0,  0,  0, 0, 0, 0,  0, 12'o2000};
        vecs[12] = '{0, 0, 0,  1,  0,  0,  3, 1,  1,  0,  0,  3, 1, 0, 1,  0, 12'o0000};
        vecs[13] = '{0, 0, 0,  1,  3,  0,  0, 0,  0,  0,  0,  0, 0, 0, 0,  0, 12'o1000};
        vecs[14] = '{0, 0, 0,  1,  0,  0,  0, 1,  0,  0,  0,  0, 0, 0, 0,  0, 12'o0000};
        vecs[15] = '{0, 0, 0,  1,  0,  0,  0, 0,  1,  0,  0,  0, 0, 0, 0,  0, 12'o0000};
        vecs[16] = '{0, 0, 0,  1,  0,  0, 10, 1,  0,  0,  0,  0, 0, 0, 0,  0, 12'o0000};
        vecs[17] = '{0, 0, 1,  0,  0,  0,  0, 0,  1, 10,  0, 11, 1, 0, 0,  0, 12'o0000};
        vecs[18] = '{0, 0, 0,  1, 11, 10,  0, 0,  0,  0,  0,  0, 0, 0, 0,  0, 12'o0300};
        vecs[19] = '{0, 0, 0,  1,  0,  0, 12, 1,  0,  0,  0,  0, 0, 0, 0,  0, 12'o0000};
        vecs[20] = '{0, 0, 0,  0,  0,  0,  0, 0,  1, 12,  0, 13, 1, 1, 0,  0, 12'o0010};
        vecs[21] = '{0, 1, 0,  1, 12, 13,  0, 0,  0,  0,  0,  0, 0, 0, 0,  0, 12'o0010};
        vecs[22] = '{0, 1, 0,  1, 12, 13,  0, 0,  0,  0,  0,  0, 0, 0, 0,  0, 12'o0010};
        vecs[23] = '{0, 1, 0,  1, 12, 13,  0, 0,  0,  0,  0,  0, 0, 0, 0,  0, 12'o0010};
        vecs[24] = '{0, 0, 0,  1, 12, 13,  0, 0,  0,  0,  0,  0, 0, 0, 0,  1, 12'o0000};
        vecs[25] = '{0, 0, 0,  1, 12, 13,  0, 0,  0,  0,  0,  0, 0, 0, 0,  0, 12'o5400};
        vecs[26] = '{0, 1, 1,  1, 12, 13,  0, 0,  0,  0,  0,  0, 0, 0, 0,  0, 12'o5400};
        vecs[27] = '{0, 0, 0,  1, 12, 13,  0, 0,  0,  0,  0,  0, 0, 0, 0,  0, 12'o0600};
        vecs[28] = '{1, 1, 0,  0,  0,  0,  0, 0,  0,  0,  0,  0, 0, 0, 0,  0, 12'o0000};
        vecs[29] = '{0, 0, 0,  1, 13,  0,  0, 0,  0,  0,  0,  0, 0, 0, 0,  0, 12'o0000};

        for (int i = 0; i < 30; i++) begin
            drive(vecs[i]);
            step($sformatf("row%0d", i), 1'b0, vecs[i].stall, vecs[i].sels);
        end

        for (int n = 0; n < 600; n++) begin
            rv.rst   = ($urandom_range(0, 99) == 0);
            rv.hold  = ($urandom_range(0, 7) == 0);
            rv.flush = ($urandom_range(0, 7) == 0);
            rv.bv    = ($urandom_range(0, 3) != 0);
            rv.brs1  = 5'($urandom_range(0, 7));
            rv.brs2  = 5'($urandom_range(0, 7));
            rv.brd   = 5'($urandom_range(0, 7));
            rv.bwe   = ($urandom_range(0, 3) != 0);
            rv.mv    = ($urandom_range(0, 3) != 0);
            rv.mrs1  = 5'($urandom_range(0, 7));
            rv.mrs2  = 5'($urandom_range(0, 7));
            rv.mrd   = 5'($urandom_range(0, 7));
            rv.mwe   = ($urandom_range(0, 3) != 0);
            rv.mload = ($urandom_range(0, 1) != 0);
            rv.mold  = ($urandom_range(0, 1) != 0);
            rv.stall = 0;
            rv.sels  = '0;
            drive(rv);
            step($sformatf("rand%0d", n), 1'b1, 1'b0, 12'o0000);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
